// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake into the buffered UART transmitter.
interface uart_tx_fifo_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_data_valid;
   logic [DATA_BITS-1:0] i_data;
   logic                 o_data_ready;

   modport master (output i_data_valid, output i_data, input  o_data_ready);
   modport slave  (input  i_data_valid, input  i_data, output o_data_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words queue in a FIFO and leave back-to-back
// as start / data (LSB first) / optional parity / stop bits.
//
// state    | meaning
// S_IDLE   | line high, waiting for a buffered word
// S_START  | start bit (low)
// S_DATA   | payload bits, LSB first
// S_PARITY | parity bit (only when PARITY != 0)
// S_STOP   | one or two stop bits (high)
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   uart_tx_fifo_if.slave                 s_in,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
   output logic                          o_busy,
   output logic                          o_tx
);
   localparam int CPB = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
   localparam int TW  = $clog2(CPB);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [TW-1:0]        r_tmr;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic [3:0]           r_bit_idx;
   logic                 r_stop_idx;
   logic                 r_tx;
   logic                 w_tx_nxt;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_tmr_zero;
   logic                 w_ready;

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_count;

   assign w_ready           = (r_count < CW'(FIFO_DEPTH));
   assign w_push            = s_in.i_data_valid & w_ready;
   assign w_tmr_zero        = (r_tmr == '0);
   assign s_in.o_data_ready = w_ready;
   assign o_fifo_count      = r_count;
   assign o_busy            = (r_state != S_IDLE) || (r_count != '0);
   assign o_tx              = r_tx;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= s_in.i_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tx_nxt    = r_tx;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tx_nxt = 1'b1;
            if (r_count != '0) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
               w_tx_nxt    = 1'b0;
            end
         end
         S_START: begin
            if (w_tmr_zero) begin
               w_state_nxt = S_DATA;
               w_tx_nxt    = r_shift[0];
            end
         end
         S_DATA: begin
            if (w_tmr_zero) begin
               if (r_bit_idx == 4'(DATA_BITS - 1)) begin
                  if (PARITY != 0) begin
                     w_state_nxt = S_PARITY;
                     w_tx_nxt    = r_par;
                  end else begin
                     w_state_nxt = S_STOP;
                     w_tx_nxt    = 1'b1;
                  end
               end else begin
                  w_tx_nxt = r_shift[1];
               end
            end
         end
         S_PARITY: begin
            if (w_tmr_zero) begin
               w_state_nxt = S_STOP;
               w_tx_nxt    = 1'b1;
            end
         end
         S_STOP: begin
            if (w_tmr_zero && (r_stop_idx == 1'(STOP_BITS - 1))) begin
               // Chain straight into the next frame when more words are queued.
               if (r_count != '0) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_START;
                  w_tx_nxt    = 1'b0;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_tx_nxt    = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx       <= 1'b1;
         r_tmr      <= '0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
      end else begin
         r_tx <= w_tx_nxt;
         if (w_pop || ((r_state != S_IDLE) && w_tmr_zero))
            r_tmr <= TW'(CPB - 1);
         else if (r_state != S_IDLE)
            r_tmr <= r_tmr - 1'b1;

         if (w_pop) begin
            r_shift    <= r_mem[r_rd_ptr];
            r_par      <= (PARITY == 1) ? ~(^r_mem[r_rd_ptr]) : (^r_mem[r_rd_ptr]);
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
         end else if ((r_state == S_DATA) && w_tmr_zero) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 1'b1;
         end else if ((r_state == S_STOP) && w_tmr_zero) begin
            r_stop_idx <= 1'b1;
         end
      end
   end
endmodule
